// File: rtl/audio_mixer_if.sv
// Bundles the audio mixer's sample-side signals into one interface.
// master: the sound-source side. It drives the strobe, the ear level and the
//         per-channel data/gain/mute, and it observes the mixed results.
// slave:  the mixer itself. It samples the inputs and drives audio,
//         audio_valid, busy, overrun and pdm.
interface audio_mixer_if #(
    parameter int CHANNELS = 4,
    parameter int IW       = 6,
    parameter int GW       = 4,
    parameter int OW       = 11
);
    logic                     ce_sample;
    logic                     ear;
    logic [CHANNELS*IW-1:0]   chan_data;
    logic [CHANNELS*GW-1:0]   chan_gain;
    logic [CHANNELS-1:0]      chan_mute;
    logic [OW-1:0]            audio;
    logic                     audio_valid;
    logic                     busy;
    logic                     overrun;
    logic                     pdm;

    modport master (
        output ce_sample, ear, chan_data, chan_gain, chan_mute,
        input  audio, audio_valid, busy, overrun, pdm
    );

    modport slave (
        input  ce_sample, ear, chan_data, chan_gain, chan_mute,
        output audio, audio_valid, busy, overrun, pdm
    );
endinterface

// File: rtl/audio_mixer.sv
// Parametrised audio mixer.
// Each sample strobe snapshots CHANNELS unsigned PCM inputs, their gains and
// their mutes, plus an optional ear bit. The mixer then accumulates one
// channel per clock, saturates the sum to OW bits and publishes it on audio
// with a one-clock audio_valid pulse. A first-order sigma-delta modulator
// turns audio into a PDM bitstream for a single-pin DAC.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-low
//   mix   - audio_mixer_if slave modport:
//           ce_sample, ear, chan_data, chan_gain, chan_mute (inputs)
//           audio, audio_valid, busy, overrun, pdm (outputs)
//
// state   | meaning
// S_IDLE  | waiting for ce_sample; inputs are latched on accept
// S_ACCUM | adds one channel product per clock, idx 0..CHANNELS-1
// S_EAR   | adds the ear contribution when EAR=1 and the ear bit is set
// S_OUT   | saturates into audio and pulses audio_valid
module audio_mixer #(
    parameter int CHANNELS = 4,
    parameter int IW       = 6,
    parameter int GW       = 4,
    parameter int OW       = 11,
    parameter int EAR      = 1
) (
    input  logic          clock,
    input  logic          reset,
    audio_mixer_if.slave  mix
);
    // Sized to hold every channel at full scale plus the ear term.
    localparam int AW   = IW + GW + $clog2(CHANNELS + 2);
    localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(CHANNELS - 1);
    localparam logic [AW-1:0]   EAR_ADD  = AW'(((1 << IW) - 1) << (GW - 1));
    localparam logic [AW-1:0]   SAT_MAX  = AW'((1 << OW) - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EAR, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [CHANNELS*IW-1:0]  data_q, data_d;
    logic [CHANNELS*GW-1:0]  gain_q, gain_d;
    logic [CHANNELS-1:0]     mute_q, mute_d;
    logic                    ear_q, ear_d;
    logic [OW-1:0]           audio_q, audio_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic [OW-1:0]           integ_q, integ_d;
    logic                    pdm_q, pdm_d;

    logic [IW-1:0]           data_sel;
    logic [GW-1:0]           gain_sel;
    logic [AW-1:0]           prod;
    logic [OW:0]             pdm_sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            acc_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            gain_q    <= '0;
            mute_q    <= '0;
            ear_q     <= 1'b0;
            audio_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            integ_q   <= '0;
            pdm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            gain_q    <= gain_d;
            mute_q    <= mute_d;
            ear_q     <= ear_d;
            audio_q   <= audio_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            integ_q   <= integ_d;
            pdm_q     <= pdm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mix.ce_sample) state_d = S_ACCUM;
            S_ACCUM: if (idx_q == IDX_LAST) state_d = S_EAR;
            S_EAR:   state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_sel  = data_q[idx_q*IW +: IW];
        gain_sel  = gain_q[idx_q*GW +: GW];
        prod      = AW'(data_sel) * AW'(gain_sel);

        acc_d     = acc_q;
        idx_d     = idx_q;
        data_d    = data_q;
        gain_d    = gain_q;
        mute_d    = mute_q;
        ear_d     = ear_q;
        audio_d   = audio_q;
        valid_d   = 1'b0;
        busy_d    = (state_d != S_IDLE);
        // A strobe outside IDLE is dropped, and that drop is remembered.
        overrun_d = overrun_q | (mix.ce_sample & (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (mix.ce_sample) begin
                    data_d = mix.chan_data;
                    gain_d = mix.chan_gain;
                    mute_d = mix.chan_mute;
                    ear_d  = mix.ear;
                    acc_d  = '0;
                    idx_d  = '0;
                end
            end
            S_ACCUM: begin
                if (!mute_q[idx_q]) acc_d = acc_q + prod;
                idx_d = idx_q + IDXW'(1);
            end
            S_EAR: begin
                if ((EAR != 0) && ear_q) acc_d = acc_q + EAR_ADD;
            end
            S_OUT: begin
                audio_d = (acc_q > SAT_MAX) ? SAT_MAX[OW-1:0] : acc_q[OW-1:0];
                valid_d = 1'b1;
            end
            default: ;
        endcase

        // The carry out of the integrator is the PDM bit, so the density of ones is audio/2^OW.
        pdm_sum = {1'b0, integ_q} + {1'b0, audio_q};
        integ_d = pdm_sum[OW-1:0];
        pdm_d   = pdm_sum[OW];
    end

    assign mix.audio       = audio_q;
    assign mix.audio_valid = valid_q;
    assign mix.busy        = busy_q;
    assign mix.overrun     = overrun_q;
    assign mix.pdm         = pdm_q;
endmodule

// File: tb/tb_audio_mixer.sv
module tb_audio_mixer;
    localparam int CH = 4;
    localparam int IW = 6;
    localparam int GW = 4;
    localparam int OW = 11;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic          ce = 1'b0;
    logic          ear_in = 1'b0;
    logic [23:0]   data = '0;
    logic [15:0]   gain = '0;
    logic [3:0]    mute = '0;

    int n_cmp = 0;
    int n_bad = 0;

    audio_mixer_if #(.CHANNELS(CH), .IW(IW), .GW(GW), .OW(OW)) bus1 ();
    audio_mixer_if #(.CHANNELS(CH), .IW(IW), .GW(GW), .OW(OW)) bus2 ();

    assign bus1.ce_sample = ce;
    assign bus1.ear       = ear_in;
    assign bus1.chan_data = data;
    assign bus1.chan_gain = gain;
    assign bus1.chan_mute = mute;
    assign bus2.ce_sample = ce;
    assign bus2.ear       = ear_in;
    assign bus2.chan_data = data;
    assign bus2.chan_gain = gain;
    assign bus2.chan_mute = mute;

    audio_mixer #(.CHANNELS(CH), .IW(IW), .GW(GW), .OW(OW), .EAR(1)) dut1 (
        .clock(clock), .reset(reset_n), .mix(bus1.slave));
    audio_mixer #(.CHANNELS(CH), .IW(IW), .GW(GW), .OW(OW), .EAR(0)) dut2 (
        .clock(clock), .reset(reset_n), .mix(bus2.slave));

    // Reference: plain weighted sum of the unmuted channels, plus the ear term, clipped to OW bits.
    function automatic int model(logic [23:0] d, logic [15:0] g, logic [3:0] m,
                                 logic e, bit ear_en);
        int s = 0;
        for (int i = 0; i < CH; i++)
            if (!m[i]) s += int'(d[i*IW +: IW]) * int'(g[i*GW +: GW]);
        if (ear_en && e) s += 63 * 8;
        return (s > 2047) ? 2047 : s;
    endfunction

    // Strobes from the current negedge and waits up to 12 edges for audio_valid.
    // Returns at the negedge where valid is first seen (lat = 0 on timeout).
    task automatic run_mix(input bit scramble, output int lat,
                           output logic [10:0] a1, output logic [10:0] a2,
                           output logic v2);
        lat = 0; a1 = '0; a2 = '0; v2 = 1'b0;
        ce = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ce = 1'b0;
        if (scramble) begin
            data = {$urandom, $urandom} >> 8;
            gain = 16'($urandom);
            mute = 4'($urandom);
            ear_in = 1'($urandom);
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus1.audio_valid === 1'b1) begin
                lat = k; a1 = bus1.audio; a2 = bus2.audio; v2 = bus2.audio_valid;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        #10;
        n_cmp++;
        if ({bus1.audio, bus1.audio_valid, bus1.busy, bus1.overrun, bus1.pdm} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {bus1.audio, bus1.audio_valid, bus1.busy, bus1.overrun, bus1.pdm});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single;
        int lat; logic [10:0] a1, a2; logic v2;
        data = 24'd0; data[5:0] = 6'd63;
        gain = 16'd0; gain[3:0] = 4'd15;
        mute = 4'b1110; ear_in = 1'b0;
        run_mix(1'b0, lat, a1, a2, v2);
        n_cmp++;
        if (lat != 6) begin n_bad++; $display("FAIL single_latency: got %0d want 6", lat); end
        n_cmp++;
        if (a1 !== 11'd945) begin n_bad++; $display("FAIL single_audio: got %0d want 945", a1); end
        n_cmp++;
        if (a2 !== 11'd945 || v2 !== 1'b1) begin
            n_bad++; $display("FAIL single_audio_noear: got %0d/%b want 945/1", a2, v2);
        end
        @(negedge clock);
        n_cmp++;
        if (bus1.audio_valid !== 1'b0 || bus1.audio !== 11'd945 || bus1.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after: valid=%b audio=%0d busy=%b want 0/945/0",
                     bus1.audio_valid, bus1.audio, bus1.busy);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        data = '1; gain = '1; mute = '0;
        ce = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ce = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (bus1.busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid: got %b want 1", bus1.busy); end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus1.audio, bus1.audio_valid, bus1.busy, bus1.overrun, bus1.pdm} !== 15'd0 ||
            {bus2.audio, bus2.busy} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {bus1.audio, bus1.audio_valid, bus1.busy, bus1.overrun, bus1.pdm});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus1.audio_valid !== 1'b0 || bus1.busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL reset_mid_after: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_saturate;
        int lat; logic [10:0] a1, a2; logic v2;
        data = {4{6'd63}}; gain = {4{4'd15}}; mute = 4'b0000; ear_in = 1'b1;
        run_mix(1'b0, lat, a1, a2, v2);
        n_cmp++;
        if (lat != 6 || a1 !== 11'd2047 || a2 !== 11'd2047) begin
            n_bad++; $display("FAIL saturate: got %0d/%0d lat %0d want 2047/2047 lat 6", a1, a2, lat);
        end
        @(negedge clock);
    endtask

    task automatic test_ear;
        int lat; logic [10:0] a1, a2; logic v2;
        data = '0; gain = {4{4'd15}}; mute = 4'b0000; ear_in = 1'b1;
        run_mix(1'b0, lat, a1, a2, v2);
        n_cmp++;
        if (a1 !== 11'd504) begin n_bad++; $display("FAIL ear_on: got %0d want 504", a1); end
        n_cmp++;
        if (a2 !== 11'd0 || v2 !== 1'b1) begin n_bad++; $display("FAIL ear_disabled: got %0d/%b want 0/1", a2, v2); end
        @(negedge clock);
    endtask

    task automatic test_random;
        int lat, e1, e2; logic [10:0] a1, a2; logic v2;
        for (int n = 0; n < 20; n++) begin
            data = {$urandom, $urandom} >> 8;
            gain = 16'($urandom);
            mute = 4'($urandom) & 4'($urandom);
            ear_in = 1'($urandom);
            e1 = model(data, gain, mute, ear_in, 1'b1);
            e2 = model(data, gain, mute, ear_in, 1'b0);
            run_mix(1'b1, lat, a1, a2, v2);
            n_cmp++;
            if (lat != 6 || int'(a1) != e1 || int'(a2) != e2) begin
                n_bad++;
                $display("FAIL random_%0d: got %0d/%0d lat %0d want %0d/%0d lat 6", n, a1, a2, lat, e1, e2);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back;
        int lat, e; logic [10:0] a1, a2; logic v2;
        data = {6'd10, 6'd20, 6'd30, 6'd40}; gain = 16'h1234; mute = 4'b0000; ear_in = 1'b0;
        run_mix(1'b0, lat, a1, a2, v2);
        data = {6'd63, 6'd1, 6'd2, 6'd3}; gain = 16'h9876; mute = 4'b0010; ear_in = 1'b1;
        e = model(data, gain, mute, ear_in, 1'b1);
        run_mix(1'b0, lat, a1, a2, v2);
        n_cmp++;
        if (lat != 6 || int'(a1) != e) begin
            n_bad++; $display("FAIL back_to_back: got %0d lat %0d want %0d lat 6", a1, lat, e);
        end
        n_cmp++;
        if (bus1.overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_no_overrun: got %b want 0", bus1.overrun); end
        @(negedge clock);
    endtask

    task automatic test_overrun;
        int lat = 0, extra = 0, e; logic [10:0] a1 = '0;
        data = {6'd5, 6'd6, 6'd7, 6'd8}; gain = {4'd1, 4'd2, 4'd3, 4'd4}; mute = 4'b0000; ear_in = 1'b0;
        e = model(data, gain, mute, ear_in, 1'b1);
        ce = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ce = 1'b0;
        @(posedge clock);
        @(negedge clock);
        data = '1; gain = '1; ce = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ce = 1'b0;
        for (int k = 3; k <= 20; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus1.audio_valid === 1'b1) begin
                if (lat == 0) begin lat = k; a1 = bus1.audio; end
                else extra++;
            end
        end
        n_cmp++;
        if (lat != 6 || int'(a1) != e) begin
            n_bad++; $display("FAIL overrun_result: got %0d lat %0d want %0d lat 6", a1, lat, e);
        end
        n_cmp++;
        if (extra != 0) begin n_bad++; $display("FAIL overrun_extra_valid: got %0d want 0", extra); end
        n_cmp++;
        if (bus1.overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b want 1", bus1.overrun); end
    endtask

    task automatic test_pdm;
        int lat, ones; logic [10:0] a1, a2; logic v2;
        data = '0; gain = '0;
        data[5:0] = 6'd60; gain[3:0] = 4'd15;
        data[11:6] = 6'd62; gain[7:4] = 4'd2;
        mute = 4'b1100; ear_in = 1'b0;
        run_mix(1'b0, lat, a1, a2, v2);
        n_cmp++;
        if (a1 !== 11'd1024) begin n_bad++; $display("FAIL pdm_setup: got %0d want 1024", a1); end
        @(negedge clock);
        ones = 0;
        for (int k = 0; k < 2048; k++) begin
            @(negedge clock);
            if (bus1.pdm === 1'b1) ones++;
        end
        n_cmp++;
        if (ones < 1023 || ones > 1025) begin n_bad++; $display("FAIL pdm_half: got %0d ones want 1024", ones); end
        mute = 4'b1111;
        run_mix(1'b0, lat, a1, a2, v2);
        @(negedge clock);
        @(negedge clock);
        ones = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (bus1.pdm !== 1'b0) ones++;
        end
        n_cmp++;
        if (a1 !== 11'd0 || ones != 0) begin
            n_bad++; $display("FAIL pdm_zero: got audio %0d ones %0d want 0/0", a1, ones);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_saturate();
        test_ear();
        test_random();
        test_back_to_back();
        test_overrun();
        test_pdm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
